// File: rtl/masking_pkg.sv
// Shared masking definitions: LFSR taps, one-step LFSR function, two-share type.
package masking_pkg;

    // Width the tap constant and step function are defined for.
    localparam int LFSR_POLY_W = 16;

    // Taps for x^16+x^14+x^13+x^11+1 in a left-shifting Fibonacci LFSR:
    // state bits 15, 13, 12 and 10 feed the XOR.
    localparam logic [LFSR_POLY_W-1:0] LFSR_POLY_TAPS = 16'hB400;

    // Two Boolean shares of one bit; the plain value is s0 ^ s1.
    typedef struct packed {
        logic s0;
        logic s1;
    } shares2_t;

    // One LFSR step: shift left and append the XOR of the tapped bits.
    function automatic logic [LFSR_POLY_W-1:0] lfsr_step(input logic [LFSR_POLY_W-1:0] s);
        logic fb;
        fb = ^(s & LFSR_POLY_TAPS);
        return {s[LFSR_POLY_W-2:0], fb};
    endfunction

    // Refresh both shares with the same mask bit; the plain value is preserved.
    function automatic shares2_t refresh_shares(input logic s0, input logic s1, input logic m);
        shares2_t r;
        r.s0 = s0 ^ m;
        r.s1 = s1 ^ m;
        return r;
    endfunction

endpackage

// File: rtl/mask_lfsr.sv
// Randomness source: 16-bit Fibonacci LFSR that advances three steps per
// consumed draw and exposes its three low bits as the current draw.
module mask_lfsr
    import masking_pkg::*;
#(
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [2:0]        rnd
);

    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] state_step3;
    logic [LFSR_W-1:0] seed_fixed;

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    assign seed_fixed = (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;

    // Three unrolled steps so each draw uses bits never handed out before.
    always_comb begin
        state_step3 = state;
        state_step3 = lfsr_step(state_step3);
        state_step3 = lfsr_step(state_step3);
        state_step3 = lfsr_step(state_step3);
    end

    // State register: reset, seed load has priority, otherwise advance or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DEFAULT_SEED;
        end else if (load) begin
            state <= seed_fixed;
        end else if (advance) begin
            state <= state_step3;
        end
    end

    assign rnd = state[2:0];

endmodule

// File: rtl/masked_ha_feeder.sv
// Register stage in front of the masked half adder. Takes two-share operands
// over valid/ready, re-masks each operand with fresh LFSR bits, registers the
// shares together with the carry-AND mask r0, and raises reseed_req after a
// configurable number of accepted transactions.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready never depends on in_valid; out_valid stays high and the
// data outputs stay bit-stable until out_ready is seen high.
module masked_ha_feeder
    import masking_pkg::*;
#(
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1,
    parameter logic [15:0]       RESEED_CNT   = 16'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_a0,
    input  logic              in_a1,
    input  logic              in_b0,
    input  logic              in_b1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              A0,
    output logic              A1,
    output logic              B0,
    output logic              B1,
    output logic              r0,
    output logic              reseed_req
);

    logic       accept;
    logic       drain;
    logic [2:0] rnd;
    shares2_t   a_next;
    shares2_t   b_next;
    shares2_t   a_q;
    shares2_t   b_q;
    logic       r0_q;
    logic       valid_q;
    logic [15:0] txn_cnt;
    logic        req_q;

    // Ready when the output slot is free or being emptied; a seed load blocks
    // acceptance so no draw straddles two seeds.
    assign in_ready = (!valid_q || out_ready) && !seed_load;
    assign accept   = in_valid && in_ready;
    assign drain    = valid_q && out_ready;

    mask_lfsr #(
        .LFSR_W       (LFSR_W),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (seed_load),
        .seed    (seed),
        .advance (accept),
        .rnd     (rnd)
    );

    // Fresh masks: bit 0 re-masks A, bit 1 re-masks B, bit 2 becomes r0.
    always_comb begin
        a_next = refresh_shares(in_a0, in_a1, rnd[0]);
        b_next = refresh_shares(in_b0, in_b1, rnd[1]);
    end

    // Output register: load on accept, clear valid on drain, otherwise hold.
    // All share bits load in the same edge, so no partial refresh is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r0_q    <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            a_q     <= a_next;
            b_q     <= b_next;
            r0_q    <= rnd[2];
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    // Transaction counter and sticky reseed request; seed load restarts both.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt <= '0;
            req_q   <= 1'b0;
        end else if (seed_load) begin
            txn_cnt <= '0;
            req_q   <= 1'b0;
        end else if (accept) begin
            if (txn_cnt != RESEED_CNT) begin
                txn_cnt <= txn_cnt + 16'd1;
            end
            if (txn_cnt == (RESEED_CNT - 16'd1)) begin
                req_q <= 1'b1;
            end
        end
    end

    assign out_valid  = valid_q;
    assign A0         = a_q.s0;
    assign A1         = a_q.s1;
    assign B0         = b_q.s0;
    assign B1         = b_q.s1;
    assign r0         = r0_q;
    assign reseed_req = req_q;

endmodule

// File: tb/tb_masked_ha_feeder.sv
// Bench for masked_ha_feeder: reference LFSR model, scoreboard queue of
// expected share outputs, table-driven stream plus hand-written corner cases.
module tb_masked_ha_feeder;

    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_a0 = 1'b0, in_a1 = 1'b0, in_b0 = 1'b0, in_b1 = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        A0, A1, B0, B1, r0;
    logic        reseed_req;

    // clock
    always #5 clk = ~clk;

    masked_ha_feeder #(
        .LFSR_W       (16),
        .DEFAULT_SEED (16'hACE1),
        .RESEED_CNT   (16'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed       (seed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a0      (in_a0),
        .in_a1      (in_a1),
        .in_b0      (in_b0),
        .in_b1      (in_b1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .A0         (A0),
        .A1         (A1),
        .B0         (B0),
        .B1         (B1),
        .r0         (r0),
        .reseed_req (reseed_req)
    );

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    // {plain_a, plain_b, A0, A1, B0, B1, r0}
    logic [6:0] exp_q[$];

    logic [15:0] m_lfsr;
    logic        m_valid;
    logic        m_req;
    int          m_cnt;
    logic        exp_a_g, exp_b_g;

    typedef struct {
        logic a0, a1, b0, b1;
        logic exp_a, exp_b;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic drive(input logic v, input logic a0, input logic a1,
                         input logic b0, input logic b1, input logic ea, input logic eb);
        in_valid = v;
        in_a0 = a0; in_a1 = a1; in_b0 = b0; in_b1 = b1;
        exp_a_g = ea; exp_b_g = eb;
    endtask

    // One cycle: check outputs mid-cycle, update the model for the coming edge.
    task automatic tick();
        logic       exp_ready;
        logic       acc;
        logic       ma, mb, mr;
        logic [6:0] e;
        @(negedge clk);
        exp_ready = (!m_valid || out_ready) && !seed_load;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("reseed_req", 32'(reseed_req), 32'(m_req));
        if (m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("shares", 32'({A0, A1, B0, B1, r0}), 32'(e[4:0]));
                check("plain", 32'({A0 ^ A1, B0 ^ B1}), 32'(e[6:5]));
                pops++;
            end
        end
        if (rst) begin
            m_valid = 1'b0;
            m_lfsr  = 16'hACE1;
            m_cnt   = 0;
            m_req   = 1'b0;
            exp_q.delete();
        end else if (seed_load) begin
            m_lfsr = (seed == 16'h0) ? 16'h0001 : seed;
            m_cnt  = 0;
            m_req  = 1'b0;
            if (m_valid && out_ready) m_valid = 1'b0;
        end else begin
            acc = in_valid && exp_ready;
            if (acc) begin
                ma = m_lfsr[0]; mb = m_lfsr[1]; mr = m_lfsr[2];
                exp_q.push_back({exp_a_g, exp_b_g, in_a0 ^ ma, in_a1 ^ ma,
                                 in_b0 ^ mb, in_b1 ^ mb, mr});
                m_lfsr = ref_step(ref_step(ref_step(m_lfsr)));
                if (m_cnt < RC) m_cnt++;
                if (m_cnt == RC) m_req = 1'b1;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] snap;
        int         p0;
        logic       ra0, ra1, rb0, rb1;

        m_valid = 1'b0; m_lfsr = 16'hACE1; m_cnt = 0; m_req = 1'b0;
        exp_a_g = 1'b0; exp_b_g = 1'b0;

        vecs[0] = '{a0:0, a1:0, b0:0, b1:0, exp_a:0, exp_b:0};
        vecs[1] = '{a0:1, a1:0, b0:0, b1:1, exp_a:1, exp_b:1};
        vecs[2] = '{a0:1, a1:1, b0:1, b1:0, exp_a:0, exp_b:1};
        vecs[3] = '{a0:0, a1:1, b0:1, b1:1, exp_a:1, exp_b:0};
        vecs[4] = '{a0:1, a1:1, b0:1, b1:1, exp_a:0, exp_b:0};
        vecs[5] = '{a0:0, a1:1, b0:0, b1:1, exp_a:1, exp_b:1};
        vecs[6] = '{a0:1, a1:0, b0:1, b1:1, exp_a:1, exp_b:0};
        vecs[7] = '{a0:0, a1:0, b0:1, b1:0, exp_a:0, exp_b:1};

        // 1) reset
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        check("reset_shares", 32'({A0, A1, B0, B1, r0}), 32'(0));
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_reseed", 32'(reseed_req), 32'(0));
        rst = 1'b0;
        tick();

        // 2) seed 1, one accept, golden values derived by hand
        seed_load = 1'b1; seed = 16'h0001;
        tick();
        seed_load = 1'b0;
        drive(1, 1, 0, 1, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("seed1_valid", 32'(out_valid), 32'(1));
        check("seed1_plain_a", 32'(A0 ^ A1), 32'(1));
        check("seed1_plain_b", 32'(B0 ^ B1), 32'(0));
        check("seed1_golden", 32'({A0, A1, B0, B1, r0}), 32'(5'b01110));
        tick();

        // 3) backpressure
        drive(1, 0, 1, 1, 0, 1, 1);
        tick();
        drive(1, 1, 1, 0, 1, 0, 1);
        out_ready = 1'b0;
        snap = {A0, A1, B0, B1, r0};
        p0 = pops;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_stable", 32'({A0, A1, B0, B1, r0}), 32'(snap));
            check("bp_no_accept", 32'(exp_q.size()), 32'(1));
        end
        out_ready = 1'b1;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("bp_transfers", 32'(pops - p0), 32'(2));
        check("bp_queue_empty", 32'(exp_q.size()), 32'(0));

        // 4) table-driven stream of 8
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            drive(1, vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1,
                  vecs[i].exp_a, vecs[i].exp_b);
            tick();
            check("stream_valid", 32'(out_valid), 32'(1));
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("stream_transfers", 32'(pops - p0), 32'(8));

        // 5) zero seed maps to 1; seed_load blocks acceptance
        seed_load = 1'b1; seed = 16'h0000;
        drive(1, 1, 0, 1, 1, 1, 0);
        tick();
        check("seedload_no_accept", 32'(exp_q.size()), 32'(0));
        seed_load = 1'b0;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("seed0_golden", 32'({A0, A1, B0, B1, r0}), 32'(5'b01110));
        tick();

        // 6) reseed request with RESEED_CNT=4
        seed_load = 1'b1; seed = 16'h1234;
        tick();
        seed_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, i[0], i[1], i[1], i[0], i[0] ^ i[1], i[1] ^ i[0]);
            tick();
            if (i == 2) check("reseed_before", 32'(reseed_req), 32'(0));
            if (i >= 3) check("reseed_set", 32'(reseed_req), 32'(1));
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        seed_load = 1'b1; seed = 16'hBEEF;
        tick();
        seed_load = 1'b0;
        check("reseed_cleared", 32'(reseed_req), 32'(0));

        // reset while holding a blocked output
        drive(1, 1, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_drop_valid", 32'(out_valid), 32'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // random traffic
        for (int i = 0; i < 60; i++) begin
            ra0 = 1'($urandom_range(0, 1)); ra1 = 1'($urandom_range(0, 1));
            rb0 = 1'($urandom_range(0, 1)); rb1 = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 1)), ra0, ra1, rb0, rb1, ra0 ^ ra1, rb0 ^ rb1);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        repeat (2) tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
